// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and 8N1 line levels.
// The transmitter is expected to pick up the same constants.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Resets to the idle line level so a held reset never looks like a start bit.
module uart_sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d_async;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronized line, mid-bit sampling, one-cycle valid/frame_err strobes.
//   state | meaning
//   IDLE  | line idle, waiting for rx_s low
//   START | half-bit wait, then confirm start bit (high -> glitch, back to IDLE)
//   DATA  | sample one data bit every CLK_PER_BIT cycles, LSB first
//   STOP  | sample stop bit; 1 -> deliver byte, 0 -> framing error
//   BREAK | line stuck low after a framing error; wait for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err
);

    localparam int HALF_BIT = CLK_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLK_PER_BIT);

    // Bit timer is a down-counter; loads are period-1 so the terminal count marks the sample cycle.
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   cnt_tc;

    uart_sync2 u_sync_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (rx),
        .q_sync  (rx_s)
    );

    assign cnt_tc = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_s == START_LEVEL) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!cnt_tc) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s == START_LEVEL) begin
                    state_d = DATA;
                    cnt_d   = BIT_LOAD;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!cnt_tc) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = BIT_LOAD;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving mid stop bit lets a back-to-back start edge be caught on time.
                if (!cnt_tc) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s == IDLE_LEVEL) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = BREAK;
                end
            end
            BREAK: begin
                if (rx_s == IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with a bit-banged 8N1 transmitter.
module tb_uart_rx;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    int last_vcyc = 0;
    logic [7:0] vq[$];

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt      <= vcnt + 1;
            last_vcyc <= cyc;
            vq.push_back(data_out);
        end
        if (frame_err) ecnt <= ecnt + 1;
        if (valid && frame_err) both <= both + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each bit ends 1 ns after a rising edge, so consecutive frames have zero gap.
    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    initial begin
        int v0, e0, b0, t0, lat, bc;
        logic [7:0] bytes [4];
        logic [7:0] ab;
        bytes[0] = 8'hA5; bytes[1] = 8'h00; bytes[2] = 8'hFF; bytes[3] = 8'h3C;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", int'(data_out), 'h00);
        check("reset_valid", int'(valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // single frame 0x55 with latency measurement
        v0 = vcnt; e0 = ecnt; b0 = vq.size(); t0 = cyc;
        send_frame(8'h55, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("x55_valid_count", vcnt - v0, 1);
        check("x55_data", (vq.size() > b0) ? int'(vq[b0]) : -1, 'h55);
        check("x55_no_frame_err", ecnt - e0, 0);
        check("x55_busy_after", int'(busy), 0);
        lat = last_vcyc - t0;
        check("latency_40pm1", int'(lat >= 39 && lat <= 41), 1);

        // back-to-back frames, no idle gap
        v0 = vcnt; e0 = ecnt; b0 = vq.size();
        for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_valid_count", vcnt - v0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_data%0d", i), (vq.size() > b0 + i) ? int'(vq[b0 + i]) : -1, int'(bytes[i]));
        check("b2b_no_frame_err", ecnt - e0, 0);

        // one-cycle glitch on the line
        v0 = vcnt; e0 = ecnt;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        bc = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("glitch_busy_window", int'(bc >= 1 && bc <= HALF + 3), 1);
        check("glitch_no_valid", vcnt - v0, 0);
        check("glitch_no_frame_err", ecnt - e0, 0);
        check("glitch_idle_after", int'(busy), 0);

        // framing error followed by a break
        v0 = vcnt; e0 = ecnt;
        send_frame(8'h81, 1'b0);
        repeat (20 * CPB) @(posedge clk);
        #1;
        check("break_busy_held", int'(busy), 1);
        check("break_one_frame_err", ecnt - e0, 1);
        check("break_no_valid", vcnt - v0, 0);
        check("break_data_kept", int'(data_out), 'h3C);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("break_idle_after_release", int'(busy), 0);
        check("break_single_err_total", ecnt - e0, 1);

        // reset during data bit 4 of 0x96, then a clean 0x96
        v0 = vcnt; e0 = ecnt;
        ab = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(ab[i]);
        rx = ab[4];
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_data_out", int'(data_out), 'h00);
        check("abort_valid", int'(valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_pulses", (vcnt - v0) + (ecnt - e0), 0);
        b0 = vq.size();
        send_frame(8'h96, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("x96_valid_count", vcnt - v0, 1);
        check("x96_data", (vq.size() > b0) ? int'(vq[b0]) : -1, 'h96);
        check("x96_no_frame_err", ecnt - e0, 0);

        check("valid_and_err_exclusive", both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); idle line high.
- Receive-side counterpart of uart_tx, with the same bit-period parameter, so a tx -> rx loopback works with matching CLK_PER_BIT.
- Delivers each received byte with a one-cycle valid strobe.
- Flags framing errors and ignores glitches that look like a start bit.

Parameters:
- CLK_PER_BIT, 4, clk cycles per serial bit. Legal range is >= 4; values below 4 are unsupported.
- HALF_BIT, CLK_PER_BIT/2 (integer division), cycles from the start edge to the first mid-bit sample. Derived; not for override.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- rx  input  1  serial line, asynchronous to clk.
- data_out  output  8  last correctly framed byte; holds until the next good frame.
- valid  output  1  one-cycle pulse; data_out is new on that same cycle.
- busy  output  1  high from start-edge detection until the frame ends.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - data_out=8'h00, valid=0, busy=0, frame_err=0.
  - Synchronizer flops = 1; state = IDLE; all counters = 0.
  - Asserting rst_n low mid-frame aborts the frame immediately. No valid or frame_err is produced for that frame.
- Input sync:
  - rx passes through 2 flops, giving rx_s.
  - All decisions use rx_s, which adds a fixed 2-cycle latency versus the raw pin.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - busy=0.
  - rx_s==0 -> START, clear the cycle counter, busy=1 from the next cycle.
- START:
  - Count HALF_BIT cycles, then sample rx_s.
  - If 0 -> DATA, counter=0, bit index=0.
  - If 1 -> treat as a glitch and return to IDLE; no pulses are produced.
- DATA:
  - Every CLK_PER_BIT cycles, sample rx_s into shift[bit index], LSB first.
  - After bit index 7 is sampled -> STOP.
- STOP:
  - After CLK_PER_BIT cycles, sample rx_s.
  - If 1: data_out <= shift and valid=1 for exactly one cycle, then -> IDLE.
  - If 0: frame_err=1 for one cycle, data_out unchanged -> BREAK.
- BREAK:
  - busy stays 1 while rx_s==0; -> IDLE on the first cycle rx_s==1.
  - A line held low (break condition) therefore yields exactly one frame_err, not repeated frames.
- Return to IDLE happens mid stop bit. This allows back-to-back frames with zero idle gap: the next falling edge is detected as soon as it arrives.
- valid and frame_err are never high in the same cycle. Each fires at most once per frame.
- End-to-end latency, from the rx falling edge at the pin to the valid pulse: 2 + HALF_BIT + 9*CLK_PER_BIT cycles, ±1 cycle edge uncertainty.
  - For CLK_PER_BIT=4 this is 40 cycles.
- No receive FIFO. A downstream consumer must take data_out by the next valid; overrun is not flagged.
- Counters are sized by $clog2(CLK_PER_BIT) and wrap only under FSM control. The bit index is 3 bits.

Decomposition:
- Shared package uart_pkg, holding:
  - the FSM state typedef (IDLE/START/DATA/STOP/BREAK);
  - constants DATA_BITS=8, IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- uart_tx later migrates to the same package.
- One sub-module: uart_sync2, a 2-flop synchronizer.
  - Async active-low reset value = 1.
  - Reused for any other asynchronous input.

Test Plan (CLK_PER_BIT=4, clk period 10 ns, one bit = 40 ns):
- Reset, then drive frame 0x55 on rx -> exactly one valid pulse with data_out=8'h55, frame_err never high, busy low afterwards.
- Loopback uart_tx -> uart_rx, sending 0xA5, 0x00, 0xFF, 0x3C back-to-back with no idle gap -> four valid pulses, in order, with matching data_out values.
- rx low for 1 cycle, then high -> returns to IDLE, no valid, no frame_err, busy high for at most HALF_BIT+3 cycles.
- Frame 0x81 with stop bit forced 0, then the line held low for 20 bit times -> one frame_err pulse, no valid, data_out keeps its previous value, busy high until rx returns to 1.
- rst_n low during data bit 4 of frame 0x96, then a clean 0x96 sent -> no output for the aborted frame, outputs at reset values, then one valid with data_out=8'h96.
- Latency check: rx falling edge at time T -> valid rises at T + 40 cycles (±1).
